pipe_ctrl: RTL and testbench

Pipeline sequencing controller between fetch, decode and execute. It tracks the destination registers of in-flight instructions (IX, MEM, WB) and detects RAW hazards against the operands presented by decode. It generates stall, bubble, flush and PC-select controls, and sequences the halt drain, IllegalOp exception entry and return-from-exception.

---
 rtl/pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: RAW interlock, redirect/exception PC select and halt drain.
// Define URISC_FWD_EN to enable operand forwarding; only load-use then interlocks.
module pipe_ctrl #(
  parameter logic [15:0] EXC_VEC = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [15:0] id_pc,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic [2:0]  id_rd,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_wr_en,
  input  logic        id_is_load,
  input  logic        id_halt,
  input  logic        id_illegal,
  input  logic        id_rte,
  input  logic        ix_redirect,
  input  logic [15:0] ix_target,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ix,
  output logic        flush_ifid,
  output logic [1:0]  pc_sel,
  output logic [15:0] pc_target,
  output logic [15:0] epc,
  output logic        in_exc,
  output logic        halted,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_epc, w_epc_d;
  logic        r_in_exc, w_in_exc_d;

  // Shadow pipe: bit 0 = IX, 1 = MEM, 2 = WB. WB only needs its valid bit.
  logic [2:0]  r_vld;
  logic [2:0]  r_rd_ix, r_rd_mem;
  logic        r_wr_ix, r_wr_mem;

  logic w_mem_stall, w_hazard, w_fire;
  logic w_rs_ix, w_rs_mem, w_rt_ix, w_rt_mem;

  assign w_mem_stall = ~mem_ready;

  assign w_rs_ix  = id_rs_used & r_vld[0] & r_wr_ix  & (r_rd_ix  == id_rs);
  assign w_rs_mem = id_rs_used & r_vld[1] & r_wr_mem & (r_rd_mem == id_rs);
  assign w_rt_ix  = id_rt_used & r_vld[0] & r_wr_ix  & (r_rd_ix  == id_rt);
  assign w_rt_mem = id_rt_used & r_vld[1] & r_wr_mem & (r_rd_mem == id_rt);

`ifdef URISC_FWD_EN
  logic r_ld_ix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_ix <= 1'b0;
    end else if (!w_mem_stall) begin
      r_ld_ix <= id_is_load;
    end
  end

  // A load in IX has no result yet; everything else is forwarded, IX before MEM.
  assign w_hazard   = id_valid & r_ld_ix & (w_rs_ix | w_rt_ix);
  assign fwd_rs_sel = w_rs_ix ? 2'd1 : (w_rs_mem ? 2'd2 : 2'd0);
  assign fwd_rt_sel = w_rt_ix ? 2'd1 : (w_rt_mem ? 2'd2 : 2'd0);
`else
  logic w_unused_ld;

  assign w_unused_ld = id_is_load;
  assign w_hazard    = id_valid & (w_rs_ix | w_rs_mem | w_rt_ix | w_rt_mem);
  assign fwd_rs_sel  = 2'd0;
  assign fwd_rt_sel  = 2'd0;
`endif

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ix  = 1'b0;
    flush_ifid = 1'b0;
    pc_sel     = 2'd0;
    pc_target  = 16'h0000;
    w_fire     = 1'b0;
    w_state_d  = r_state;
    w_epc_d    = r_epc;
    w_in_exc_d = r_in_exc;
    case (r_state)
      StRun: begin
        if (w_mem_stall) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end else if (ix_redirect) begin
          flush_ifid = 1'b1;
          bubble_ix  = 1'b1;
          pc_sel     = 2'd1;
          pc_target  = ix_target;
        end else if (w_hazard) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ix = 1'b1;
        end else if (id_valid) begin
          w_fire = 1'b1;
          if (id_illegal && !r_in_exc) begin
            w_epc_d    = id_pc + 16'd2;
            w_in_exc_d = 1'b1;
            pc_sel     = 2'd2;
            pc_target  = EXC_VEC;
            flush_ifid = 1'b1;
            bubble_ix  = 1'b1;
          end else if (id_illegal) begin
            // Fault inside the handler: no way to recover, so stop.
            bubble_ix = 1'b1;
            w_state_d = StDrain;
          end else if (id_rte) begin
            pc_sel     = 2'd3;
            pc_target  = r_epc;
            w_in_exc_d = 1'b0;
            flush_ifid = 1'b1;
            bubble_ix  = 1'b1;
          end else if (id_halt) begin
            bubble_ix = 1'b1;
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ix = ~w_mem_stall;
        if (r_vld == 3'b000) begin
          w_state_d = StHalted;
        end
      end
      StHalted: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      default: begin
        w_state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StRun;
      r_epc    <= 16'h0000;
      r_in_exc <= 1'b0;
      r_vld    <= 3'b000;
      r_rd_ix  <= 3'd0;
      r_rd_mem <= 3'd0;
      r_wr_ix  <= 1'b0;
      r_wr_mem <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_epc    <= w_epc_d;
      r_in_exc <= w_in_exc_d;
      if (!w_mem_stall) begin
        r_vld    <= {r_vld[1:0], w_fire};
        r_rd_mem <= r_rd_ix;
        r_wr_mem <= r_wr_ix;
        r_rd_ix  <= id_rd;
        r_wr_ix  <= id_wr_en;
      end
    end
  end

  assign epc    = r_epc;
  assign in_exc = r_in_exc;
  assign halted = (r_state == StHalted);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan scenarios plus randomized run
// against a queue-style reference model of the sequencing rules.
module tb_pipe_ctrl;

`ifdef URISC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int StallDepth = FWD ? 1 : 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic        id_halt, id_illegal, id_rte, ix_redirect, mem_ready;
  logic [15:0] id_pc, ix_target;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        stall_if, stall_id, bubble_ix, flush_ifid, in_exc, halted;
  logic [1:0]  pc_sel, fwd_rs_sel, fwd_rt_sel;
  logic [15:0] pc_target, epc;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_halt(id_halt), .id_illegal(id_illegal), .id_rte(id_rte),
    .ix_redirect(ix_redirect), .ix_target(ix_target), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ix(bubble_ix), .flush_ifid(flush_ifid),
    .pc_sel(pc_sel), .pc_target(pc_target), .epc(epc), .in_exc(in_exc), .halted(halted),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions as a 3-slot list, mode 0 run / 1 drain / 2 halted.
  typedef struct packed {logic v; logic [2:0] rd; logic wr; logic ld;} ent_t;
  typedef struct packed {
    logic sif, sid, bub, fl; logic [1:0] sel; logic [15:0] tgt; logic [1:0] frs, frt; logic fire;
  } exp_t;

  ent_t        m_pipe [3];
  int          m_mode;
  logic [15:0] m_epc;
  logic        m_inexc;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_mode  = 0;
    m_epc   = 16'h0000;
    m_inexc = 1'b0;
  endfunction

  function automatic logic must_wait(input logic used, input logic [2:0] src);
    for (int s = 0; s < StallDepth; s++)
      if (used && m_pipe[s].v && m_pipe[s].wr && m_pipe[s].rd == src && (!FWD || m_pipe[s].ld))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_src(input logic used, input logic [2:0] src);
    for (int s = 0; s < 2; s++)
      if (FWD && used && m_pipe[s].v && m_pipe[s].wr && m_pipe[s].rd == src) return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic exp_t predict();
    exp_t e = '0;
    logic hz = id_valid && (must_wait(id_rs_used, id_rs) || must_wait(id_rt_used, id_rt));
    e.frs = fwd_src(id_rs_used, id_rs);
    e.frt = fwd_src(id_rt_used, id_rt);
    if (m_mode != 0) begin
      e.sif = 1'b1; e.sid = 1'b1; e.bub = (m_mode == 1) && mem_ready;
    end else if (!mem_ready) begin
      e.sif = 1'b1; e.sid = 1'b1;
    end else if (ix_redirect) begin
      e.fl = 1'b1; e.bub = 1'b1; e.sel = 2'd1; e.tgt = ix_target;
    end else if (hz) begin
      e.sif = 1'b1; e.sid = 1'b1; e.bub = 1'b1;
    end else if (id_valid) begin
      e.fire = 1'b1;
      if (id_illegal && !m_inexc) begin
        e.sel = 2'd2; e.tgt = 16'h0002; e.fl = 1'b1; e.bub = 1'b1;
      end else if (id_illegal || (!id_rte && id_halt)) begin
        e.bub = 1'b1;
      end else if (id_rte) begin
        e.sel = 2'd3; e.tgt = m_epc; e.fl = 1'b1; e.bub = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic void commit(input exp_t e);
    int nxt = m_mode;
    if (e.fire) begin
      if (id_illegal && !m_inexc) begin m_epc = id_pc + 16'd2; m_inexc = 1'b1; end
      else if (id_illegal) nxt = 1;
      else if (id_rte) m_inexc = 1'b0;
      else if (id_halt) nxt = 1;
    end
    if (m_mode == 1 && !m_pipe[0].v && !m_pipe[1].v && !m_pipe[2].v) nxt = 2;
    if (mem_ready) begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = e.fire ? ent_t'{1'b1, id_rd, id_wr_en, id_is_load} : ent_t'('0);
    end
    m_mode = nxt;
  endfunction

  task automatic idle();
    id_valid = 0; id_pc = 16'h0; id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd0;
    id_rs_used = 0; id_rt_used = 0; id_wr_en = 0; id_is_load = 0;
    id_halt = 0; id_illegal = 0; id_rte = 0; ix_redirect = 0; ix_target = 16'h0; mem_ready = 1;
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                       input logic rsu, input logic rtu, input logic wr, input logic ld);
    idle();
    id_valid = 1; id_rd = rd; id_rs = rs; id_rt = rt;
    id_rs_used = rsu; id_rt_used = rtu; id_wr_en = wr; id_is_load = ld;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    next();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #2;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (in_exc !== 1'b0) begin n_fail++; $display("FAIL reset_in_exc got=%b exp=0", in_exc); end
    n_checks++; if (epc !== 16'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0000", epc); end
    n_checks++; if ({stall_if, stall_id, bubble_ix, flush_ifid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {stall_if, stall_id, bubble_ix, flush_ifid});
    end
    n_checks++; if (pc_sel !== 2'd0 || pc_target !== 16'h0) begin
      n_fail++; $display("FAIL reset_pc got=%0d/%h exp=0/0000", pc_sel, pc_target);
    end
    rst = 1'b1;
    model_reset();
    next();
  endtask

  task automatic test_raw_hazard();
    int stalls = 0;
    logic fired = 1'b0;
    do_reset();
    issue(3'd1, 3'd2, 3'd3, 1, 1, 1, 0);
    #2;
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL raw_producer stall_id got=%b exp=0", stall_id); end
    next();
    issue(3'd4, 3'd1, 3'd0, 1, 0, 1, 0);
    for (int c = 0; c < 6 && !fired; c++) begin
      #2;
      if (stall_id === 1'b0) begin
        fired = 1'b1;
        n_checks++; if (fwd_rs_sel !== (FWD ? 2'd1 : 2'd0)) begin
          n_fail++; $display("FAIL raw_fwd_rs got=%0d exp=%0d", fwd_rs_sel, FWD ? 1 : 0);
        end
      end else begin
        stalls++;
        n_checks++; if (bubble_ix !== 1'b1 || stall_if !== 1'b1) begin
          n_fail++; $display("FAIL raw_stall_bubble got=%b%b exp=11", bubble_ix, stall_if);
        end
      end
      next();
    end
    n_checks++; if (!fired || stalls != (FWD ? 0 : 2)) begin
      n_fail++; $display("FAIL raw_stall_cycles got=%0d fired=%b exp=%0d", stalls, fired, FWD ? 0 : 2);
    end
    idle();
  endtask

  task automatic test_load_use();
    int stalls = 0;
    logic fired = 1'b0;
    do_reset();
    issue(3'd2, 3'd0, 3'd0, 0, 0, 1, 1);
    next();
    issue(3'd5, 3'd0, 3'd2, 0, 1, 1, 0);
    for (int c = 0; c < 6 && !fired; c++) begin
      #2;
      if (stall_id === 1'b0) begin
        fired = 1'b1;
        n_checks++; if (fwd_rt_sel !== (FWD ? 2'd2 : 2'd0)) begin
          n_fail++; $display("FAIL ldu_fwd_rt got=%0d exp=%0d", fwd_rt_sel, FWD ? 2 : 0);
        end
      end else begin
        stalls++;
      end
      next();
    end
    n_checks++; if (!fired || stalls != (FWD ? 1 : 2)) begin
      n_fail++; $display("FAIL ldu_stall_cycles got=%0d fired=%b exp=%0d", stalls, fired, FWD ? 1 : 2);
    end
    idle();
  endtask

  task automatic test_redirect();
    do_reset();
    issue(3'd1, 3'd0, 3'd0, 0, 0, 1, 0);
    next();
    issue(3'd3, 3'd1, 3'd0, 1, 0, 1, 1);
    id_illegal = 1; id_pc = 16'h0050; ix_redirect = 1; ix_target = 16'h0040;
    #2;
    n_checks++; if (pc_sel !== 2'd1 || pc_target !== 16'h0040) begin
      n_fail++; $display("FAIL redir_pc got=%0d/%h exp=1/0040", pc_sel, pc_target);
    end
    n_checks++; if ({flush_ifid, bubble_ix, stall_id} !== 3'b110) begin
      n_fail++; $display("FAIL redir_ctrl got=%b exp=110", {flush_ifid, bubble_ix, stall_id});
    end
    next();
    idle();
    #2;
    n_checks++; if (epc !== 16'h0 || in_exc !== 1'b0) begin
      n_fail++; $display("FAIL redir_no_exc got=%h/%b exp=0000/0", epc, in_exc);
    end
    next();
  endtask

  task automatic test_exception();
    do_reset();
    idle(); id_valid = 1; id_illegal = 1; id_pc = 16'h0010;
    #2;
    n_checks++; if (pc_sel !== 2'd2 || pc_target !== 16'h0002 || flush_ifid !== 1'b1) begin
      n_fail++; $display("FAIL exc_entry got=%0d/%h/%b exp=2/0002/1", pc_sel, pc_target, flush_ifid);
    end
    next();
    idle();
    #2;
    n_checks++; if (epc !== 16'h0012 || in_exc !== 1'b1) begin
      n_fail++; $display("FAIL exc_epc got=%h/%b exp=0012/1", epc, in_exc);
    end
    next();
    idle(); id_valid = 1; id_rte = 1;
    #2;
    n_checks++; if (pc_sel !== 2'd3 || pc_target !== 16'h0012) begin
      n_fail++; $display("FAIL rte_pc got=%0d/%h exp=3/0012", pc_sel, pc_target);
    end
    next();
    idle();
    #2;
    n_checks++; if (in_exc !== 1'b0) begin n_fail++; $display("FAIL rte_in_exc got=%b exp=0", in_exc); end
    next();
    idle(); id_valid = 1; id_illegal = 1; id_pc = 16'hFFFF;
    next();
    idle(); id_valid = 1; id_illegal = 1; id_pc = 16'h0040;
    #2;
    n_checks++; if (pc_sel !== 2'd0 || bubble_ix !== 1'b1 || flush_ifid !== 1'b0) begin
      n_fail++; $display("FAIL nested_ctrl got=%0d/%b/%b exp=0/1/0", pc_sel, bubble_ix, flush_ifid);
    end
    next();
    idle();
    #2;
    n_checks++; if (epc !== 16'h0001 || stall_if !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL nested_drain got=%h/%b/%b exp=0001/1/0", epc, stall_if, halted);
    end
    for (int c = 0; c < 8 && halted !== 1'b1; c++) begin next(); #2; end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL nested_halted got=%b exp=1", halted); end
    next();
  endtask

  task automatic test_halt_mem_stall();
    int cnt = 0;
    do_reset();
    idle(); id_valid = 1; id_halt = 1;
    #2;
    n_checks++; if (bubble_ix !== 1'b1 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL halt_fire got=%b%b exp=10", bubble_ix, stall_if);
    end
    next();
    idle(); mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++; if ({stall_if, stall_id, bubble_ix, halted} !== 4'b1100) begin
        n_fail++; $display("FAIL halt_frozen got=%b exp=1100", {stall_if, stall_id, bubble_ix, halted});
      end
      next();
    end
    mem_ready = 1;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (halted === 1'b1) break;
      cnt++;
      next();
    end
    n_checks++; if (halted !== 1'b1 || cnt != 4) begin
      n_fail++; $display("FAIL halt_drain_cycles got=%0d halted=%b exp=4", cnt, halted);
    end
    rst = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL halt_async_reset got=%b%b exp=00", halted, stall_if);
    end
    rst = 1'b1;
    model_reset();
    next();
  endtask

  task automatic test_mem_stall_hazard();
    int stalls = 0;
    logic fired = 1'b0;
    do_reset();
    issue(3'd6, 3'd0, 3'd0, 0, 0, 1, 0);
    next();
    issue(3'd2, 3'd6, 3'd0, 1, 0, 1, 0);
    mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++; if ({stall_if, stall_id, bubble_ix, flush_ifid, pc_sel} !== 6'b110000) begin
        n_fail++; $display("FAIL memstall_ctrl got=%b exp=110000", {stall_if, stall_id, bubble_ix, flush_ifid, pc_sel});
      end
      next();
    end
    mem_ready = 1;
    for (int c = 0; c < 6 && !fired; c++) begin
      #2;
      if (stall_id === 1'b0) fired = 1'b1;
      else stalls++;
      next();
    end
    n_checks++; if (!fired || stalls != (FWD ? 0 : 2)) begin
      n_fail++; $display("FAIL memstall_then_hazard got=%0d fired=%b exp=%0d", stalls, fired, FWD ? 0 : 2);
    end
    idle();
  endtask

  task automatic test_random();
    exp_t e;
    int halted_cycles = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_pc       = 16'($urandom);
      id_rs       = 3'($urandom_range(0, 3));
      id_rt       = 3'($urandom_range(0, 3));
      id_rd       = 3'($urandom_range(0, 3));
      id_rs_used  = 1'($urandom_range(0, 1));
      id_rt_used  = 1'($urandom_range(0, 1));
      id_wr_en    = 1'($urandom_range(0, 1));
      id_is_load  = ($urandom_range(0, 2) == 0);
      id_halt     = ($urandom_range(0, 49) == 0);
      id_illegal  = ($urandom_range(0, 24) == 0);
      id_rte      = ($urandom_range(0, 19) == 0);
      ix_redirect = ($urandom_range(0, 9) == 0);
      ix_target   = 16'($urandom);
      mem_ready   = ($urandom_range(0, 4) != 0);
      #2;
      e = predict();
      n_checks++;
      if ({stall_if, stall_id, bubble_ix, flush_ifid, pc_sel, pc_target, fwd_rs_sel, fwd_rt_sel} !==
          {e.sif, e.sid, e.bub, e.fl, e.sel, e.tgt, e.frs, e.frt}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got=%b_%0d_%h_%0d%0d exp=%b_%0d_%h_%0d%0d", c,
                 {stall_if, stall_id, bubble_ix, flush_ifid}, pc_sel, pc_target, fwd_rs_sel, fwd_rt_sel,
                 {e.sif, e.sid, e.bub, e.fl}, e.sel, e.tgt, e.frs, e.frt);
      end
      n_checks++;
      if ({epc, in_exc, halted} !== {m_epc, m_inexc, (m_mode == 2)}) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d got=%h/%b/%b exp=%h/%b/%b", c, epc, in_exc, halted,
                 m_epc, m_inexc, (m_mode == 2));
      end
      commit(e);
      next();
      halted_cycles = (m_mode == 2) ? halted_cycles + 1 : 0;
      if (halted_cycles > 3 || $urandom_range(0, 99) == 0) begin
        do_reset();
        halted_cycles = 0;
      end
    end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_raw_hazard();
    test_load_use();
    test_redirect();
    test_exception();
    test_halt_mem_stall();
    test_mem_stall_hazard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
